inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller with a 2-entry {instr, pc} buffer; one cycle from imem_addr to instr_out.
// Fetch stops when the buffer is full and the head is not taken. Redirect flushes and retargets; halt stops fetching while decode drains.
module inst_fetch_ctrl #(
  parameter int              WORD = 16,
  parameter int              PCL  = 10,
  parameter logic [WORD-1:0] NOP  = 16'b1000000001000000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PCL-1:0]  imem_addr,
  input  logic [WORD-1:0] imem_data,
  output logic [WORD-1:0] instr_out,
  output logic [PCL-1:0]  instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [PCL-1:0]  redirect_pc,
  input  logic            halt,
  input  logic            resume,
  output logic            halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

  state_t          r_state;
  logic            r_halted;
  logic [PCL-1:0]  r_fetch_pc;
  logic [1:0]      r_count;
  logic [WORD-1:0] r_dat0, r_dat1;
  logic [PCL-1:0]  r_pc0, r_pc1;

  logic w_pop;
  logic w_push;

  // A redirect cancels both the pop and the push of its cycle.
  assign w_pop  = (r_count != 2'd0) && instr_ready && !redirect_valid;
  assign w_push = (r_state == S_FETCH) && !halt && !redirect_valid &&
                  ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_halted   <= 1'b0;
      r_fetch_pc <= '0;
      r_count    <= 2'd0;
      r_dat0     <= '0;
      r_dat1     <= '0;
      r_pc0      <= '0;
      r_pc1      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state  <= S_FETCH;
          r_halted <= 1'b0;
        end
        S_FETCH: begin
          if (halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (resume && !halt) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase

      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_count    <= 2'd0;
      end else begin
        if (w_push) r_fetch_pc <= r_fetch_pc + PCL'(1);
        // Entry 0 is always the head; entry 1 shifts down on a pop.
        case ({w_push, w_pop})
          2'b10: begin
            if (r_count == 2'd0) begin
              r_dat0 <= imem_data;
              r_pc0  <= r_fetch_pc;
            end else begin
              r_dat1 <= imem_data;
              r_pc1  <= r_fetch_pc;
            end
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            r_dat0  <= r_dat1;
            r_pc0   <= r_pc1;
            r_count <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd1) begin
              r_dat0 <= imem_data;
              r_pc0  <= r_fetch_pc;
            end else begin
              r_dat0 <= r_dat1;
              r_pc0  <= r_pc1;
              r_dat1 <= imem_data;
              r_pc1  <= r_fetch_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr_out   = instr_valid ? r_dat0 : NOP;
  assign instr_pc    = instr_valid ? r_pc0 : '0;
  assign halted      = r_halted;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: constant vector table, directed corner sequences and a
// randomized run, all also compared against a queue-based reference model.
module tb_inst_fetch_ctrl;
  localparam logic [15:0] NOP = 16'h8040;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halt;
  logic        resume;
  logic        halted;
  logic [15:0] mem_xor = 16'h0000;

  assign imem_data = {6'b0, imem_addr} ^ mem_xor;

  inst_fetch_ctrl #(.WORD(16), .PCL(10), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .resume(resume), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] d; logic [9:0] pc; } ent_t;
  typedef struct {
    logic rst, rdy, vld;
    logic [15:0] out;
    logic [9:0]  pc, addr;
  } vec_t;

  ent_t mq[$];
  int   m_pc;
  int   m_mode;  // 0 idle, 1 fetching, 2 halted
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit r, input bit rdy, input bit rv, input logic [9:0] rp,
                     input bit h, input bit rs);
    rst = r; instr_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    halt = h; resume = rs;
  endtask

  task automatic model_tick();
    bit   pop, push;
    ent_t e;
    if (rst) begin
      mq.delete(); m_pc = 0; m_mode = 0;
    end else begin
      if (redirect_valid) begin
        mq.delete();
        m_pc = int'(redirect_pc);
      end else begin
        pop  = (mq.size() > 0) && instr_ready;
        push = (m_mode == 1) && !halt && ((mq.size() < 2) || pop);
        e.d  = 16'(m_pc) ^ mem_xor;
        e.pc = 10'(m_pc);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(e);
          m_pc = (m_pc + 1) % 1024;
        end
      end
      case (m_mode)
        0: m_mode = 1;
        1: if (halt) m_mode = 2;
        2: if (resume && !halt) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step();
    logic [15:0] e_out;
    logic [9:0]  e_pc;
    model_tick();
    @(posedge clk);
    #1;
    e_out = NOP; e_pc = '0;
    if (mq.size() != 0) begin
      e_out = mq[0].d; e_pc = mq[0].pc;
    end
    chk("instr_valid", instr_valid, mq.size() != 0);
    chk("instr_out", instr_out, e_out);
    chk("instr_pc", instr_pc, e_pc);
    chk("halted", halted, m_mode == 2);
    chk("imem_addr", imem_addr, m_pc);
  endtask

  task automatic add(input bit r, input bit rdy, input bit vld, input logic [15:0] out,
                     input logic [9:0] pc, input logic [9:0] addr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.vld = vld; v.out = out; v.pc = pc; v.addr = addr;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drv(1, 0, 0, '0, 0, 0);

    // ready held high from reset, then ready held low until the buffer saturates
    add(1, 1, 0, NOP, 0, 0);
    add(0, 1, 0, NOP, 0, 0);
    add(0, 1, 1, 16'h0000, 0, 1);
    add(0, 1, 1, 16'h0001, 1, 2);
    add(0, 1, 1, 16'h0002, 2, 3);
    add(0, 1, 1, 16'h0003, 3, 4);
    add(1, 0, 0, NOP, 0, 0);
    add(0, 0, 0, NOP, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 1);
    add(0, 0, 1, 16'h0000, 0, 2);
    add(0, 0, 1, 16'h0000, 0, 2);
    add(0, 0, 1, 16'h0000, 0, 2);
    add(0, 1, 1, 16'h0001, 1, 3);
    add(0, 1, 1, 16'h0002, 2, 4);
    add(0, 1, 1, 16'h0003, 3, 5);
    foreach (tbl[i]) begin
      drv(tbl[i].rst, tbl[i].rdy, 0, '0, 0, 0);
      step();
      chk("tbl_valid", instr_valid, tbl[i].vld);
      chk("tbl_out", instr_out, tbl[i].out);
      chk("tbl_pc", instr_pc, tbl[i].pc);
      chk("tbl_halted", halted, 1'b0);
      chk("tbl_addr", imem_addr, tbl[i].addr);
    end

    // redirect while full, then redirect to the top of the address space
    drv(1, 0, 0, '0, 0, 0); step();
    drv(0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("full_addr", imem_addr, 10'd2);
    drv(0, 1, 1, 10'h1F0, 0, 0); step();
    chk("redir_flush_valid", instr_valid, 1'b0);
    chk("redir_addr", imem_addr, 10'h1F0);
    drv(0, 1, 0, '0, 0, 0); step();
    chk("redir_first_valid", instr_valid, 1'b1);
    chk("redir_first_pc", instr_pc, 10'h1F0);
    chk("redir_first_out", instr_out, 16'h01F0);
    drv(0, 1, 1, 10'h3FF, 0, 0); step();
    chk("wrap_flush_valid", instr_valid, 1'b0);
    drv(0, 1, 0, '0, 0, 0); step();
    chk("wrap_pc0", instr_pc, 10'h3FF);
    step();
    chk("wrap_pc1", instr_pc, 10'h000);
    step();
    chk("wrap_pc2", instr_pc, 10'h001);

    // halt with a full buffer drains it; resume continues sequentially
    drv(1, 0, 0, '0, 0, 0); step();
    drv(0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    drv(0, 1, 0, '0, 1, 0); step();
    chk("halt_halted", halted, 1'b1);
    chk("halt_drain_pc", instr_pc, 10'd1);
    drv(0, 1, 0, '0, 0, 0); step();
    chk("halt_empty_valid", instr_valid, 1'b0);
    chk("halt_empty_out", instr_out, NOP);
    step();
    chk("halt_hold_addr", imem_addr, 10'd2);
    chk("halt_hold_halted", halted, 1'b1);
    drv(0, 1, 0, '0, 1, 1); step();
    chk("halt_wins_halted", halted, 1'b1);
    drv(0, 1, 0, '0, 0, 1); step();
    chk("resume_halted", halted, 1'b0);
    drv(0, 1, 0, '0, 0, 0); step();
    chk("resume_pc", instr_pc, 10'd2);

    // reset while halted with one entry buffered
    drv(1, 0, 0, '0, 0, 0); step();
    drv(0, 0, 0, '0, 0, 0); step(); step();
    drv(0, 0, 0, '0, 1, 0); step();
    drv(0, 0, 0, '0, 0, 0); step();
    chk("pre_rst_halted", halted, 1'b1);
    chk("pre_rst_valid", instr_valid, 1'b1);
    drv(1, 0, 0, '0, 0, 0); step();
    chk("rst_halt_valid", instr_valid, 1'b0);
    chk("rst_halt_halted", halted, 1'b0);
    chk("rst_halt_addr", imem_addr, 10'd0);

    // randomized traffic against the reference model
    mem_xor = 16'hA5C3;
    for (int i = 0; i < 2000; i++) begin
      drv($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0,
          10'($urandom_range(0, 1023)),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 4) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
